lpc_reg_rd_mux: RTL and testbench

- Parametrised LPC register read multiplexer; generation 2 of the CPLD LPC read-data path.
- Sits in the LPC block between the register file / status sources and the LPC read-cycle engine.
- Adds over the previous generation:
  - configurable width, register count and pipeline depth;
  - multiple status-overlay channels with sticky, clear-on-read event bits;
  - a request/valid/busy handshake with an out-of-range error flag.

---
 rtl/lpc_reg_rd_mux.sv | 174 +++++++++++++++++
 tb/tb_lpc_reg_rd_mux.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lpc_reg_rd_mux.sv
// LPC register read multiplexer: register file / status-overlay read path with
// configurable latency. Define LPC_RD_OVERRUN_EN to enable the dropped-request flag.
`timescale 1ns/1ps

module lpc_reg_rd_mux #(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 8,
    parameter int NUM_STS  = 2,
    parameter int STS_BASE = 4,
    parameter int RD_LAT   = 1
) (
    input  logic                        LpcClock,
    input  logic                        PciReset,
    input  logic                        RdReq,
    input  logic [ADDR_W-1:0]           AddrReg,
    input  logic [NUM_REGS*DATA_W-1:0]  DataReg,
    input  logic [NUM_STS*DATA_W-1:0]   StatusIn,
    input  logic [NUM_STS*DATA_W-1:0]   StsEvent,
    output logic [DATA_W-1:0]           DataRd,
    output logic                        RdValid,
    output logic                        RdErr,
    output logic                        Busy,
    output logic                        RdOverrun
);

    localparam int                CNT_W  = 2;
    localparam logic [CNT_W-1:0]  LAT_M1 = CNT_W'(RD_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PIPE = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [DATA_W-1:0]          cap_data_q, cap_data_d;
    logic                       cap_err_q, cap_err_d;
    logic [DATA_W-1:0]          rd_data_q, rd_data_d;
    logic                       rd_err_q, rd_err_d;
    logic [NUM_STS*DATA_W-1:0]  sticky_q, sticky_d;

    logic                       busy;
    logic                       accept;
    logic [31:0]                addr_ext;
    logic [DATA_W-1:0]          mux_data;
    logic                       mux_err;
    logic [NUM_STS*DATA_W-1:0]  sts_hit;

    assign busy     = (state_q == S_PIPE);
    assign accept   = RdReq & ~busy;
    assign addr_ext = 32'(AddrReg);

    // Read decode: status channels override the register file at their addresses.
    always_comb begin
        // NOTE: every combinationally assigned signal gets a default first, so no path infers a latch.
        mux_data = '0;
        mux_err  = 1'b1;
        sts_hit  = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (addr_ext == 32'(k)) begin
                mux_data = DataReg[k*DATA_W +: DATA_W];
                mux_err  = 1'b0;
            end
        end
        for (int i = 0; i < NUM_STS; i++) begin
            if (addr_ext == 32'(STS_BASE + i)) begin
                mux_data = StatusIn[i*DATA_W +: DATA_W] | sticky_q[i*DATA_W +: DATA_W];
                sts_hit[i*DATA_W +: DATA_W] = '1;
            end
        end
    end

    // Clear on an accepted read of the channel, but a same-edge event keeps the bit set.
    assign sticky_d = (sticky_q & ~({(NUM_STS*DATA_W){accept}} & sts_hit)) | StsEvent;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cap_data_d = cap_data_q;
        cap_err_d  = cap_err_q;
        rd_data_d  = rd_data_q;
        rd_err_d   = 1'b0;

        unique case (state_q)
            S_IDLE, S_RESP: begin
                state_d = S_IDLE;
                if (accept) begin
                    cap_data_d = mux_data;
                    cap_err_d  = mux_err;
                    if (RD_LAT == 1) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_PIPE;
                        cnt_d   = LAT_M1;
                    end
                end
            end
            S_PIPE: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_RESP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Single-cycle latency loads straight from the decoder; deeper pipes use the capture.
        if (state_d == S_RESP) begin
            if (state_q == S_PIPE) begin
                rd_data_d = cap_data_q;
                rd_err_d  = cap_err_q;
            end else begin
                rd_data_d = mux_data;
                rd_err_d  = mux_err;
            end
        end
    end

    always_ff @(posedge LpcClock or negedge PciReset) begin
        if (!PciReset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            cap_data_q <= '0;
            cap_err_q  <= 1'b0;
            rd_data_q  <= '0;
            rd_err_q   <= 1'b0;
            sticky_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cap_data_q <= cap_data_d;
            cap_err_q  <= cap_err_d;
            rd_data_q  <= rd_data_d;
            rd_err_q   <= rd_err_d;
            sticky_q   <= sticky_d;
        end
    end

`ifdef LPC_RD_OVERRUN_EN
    logic ovr_q, ovr_d;

    always_comb begin
        ovr_d = ovr_q;
        if (RdReq && busy) begin
            ovr_d = 1'b1;
        end else if (accept) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge LpcClock or negedge PciReset) begin
        if (!PciReset) begin
            ovr_q <= 1'b0;
        end else begin
            ovr_q <= ovr_d;
        end
    end

    assign RdOverrun = ovr_q;
`else
    assign RdOverrun = 1'b0;
`endif

    assign DataRd  = rd_data_q;
    assign RdValid = (state_q == S_RESP);
    assign RdErr   = rd_err_q;
    assign Busy    = busy;

endmodule

// File: tb/tb_lpc_reg_rd_mux.sv
// Bench for lpc_reg_rd_mux: four instances (RD_LAT 1..4) on shared stimulus,
// checked every cycle against a transaction-level model plus directed vectors.
`timescale 1ns/1ps

module tb_lpc_reg_rd_mux;

    localparam int DATA_W   = 8;
    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 8;
    localparam int NUM_STS  = 2;
    localparam int STS_BASE = 4;
    localparam int NDUT     = 4;
`ifdef LPC_RD_OVERRUN_EN
    localparam bit OVR_EN = 1'b1;
`else
    localparam bit OVR_EN = 1'b0;
`endif

    logic                         clk = 1'b0;
    logic                         rst_n;
    logic                         rd_req;
    logic [ADDR_W-1:0]            addr;
    logic [NUM_REGS*DATA_W-1:0]   data_reg;
    logic [NUM_STS*DATA_W-1:0]    status_in;
    logic [NUM_STS*DATA_W-1:0]    sts_event;
    logic [NDUT-1:0][DATA_W-1:0]  data_rd;
    logic [NDUT-1:0]              rd_valid, rd_err, busy, rd_ovr;

    always #15 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        lpc_reg_rd_mux #(
            .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W),
            .NUM_STS(NUM_STS), .STS_BASE(STS_BASE), .RD_LAT(g + 1)
        ) u_dut (
            .LpcClock (clk),
            .PciReset (rst_n),
            .RdReq    (rd_req),
            .AddrReg  (addr),
            .DataReg  (data_reg),
            .StatusIn (status_in),
            .StsEvent (sts_event),
            .DataRd   (data_rd[g]),
            .RdValid  (rd_valid[g]),
            .RdErr    (rd_err[g]),
            .Busy     (busy[g]),
            .RdOverrun(rd_ovr[g])
        );
    end

    int n_cmp;
    int n_bad;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: each read is an accept cycle, a due cycle and a value.
    int          cyc;
    int          last_acc  [NDUT];
    int          pend_due  [NDUT];
    logic [7:0]  pend_data [NDUT];
    bit          pend_err  [NDUT];
    logic [7:0]  m_sticky  [NDUT][NUM_STS];
    logic [7:0]  exp_data  [NDUT];
    bit          exp_valid [NDUT];
    bit          exp_err   [NDUT];
    bit          exp_busy  [NDUT];
    bit          exp_ovr   [NDUT];

    function automatic void model_reset();
        for (int d = 0; d < NDUT; d++) begin
            last_acc[d]  = -100;
            pend_due[d]  = -1;
            pend_data[d] = '0;
            pend_err[d]  = 1'b0;
            exp_data[d]  = '0;
            exp_valid[d] = 1'b0;
            exp_err[d]   = 1'b0;
            exp_busy[d]  = 1'b0;
            exp_ovr[d]   = 1'b0;
            for (int i = 0; i < NUM_STS; i++) m_sticky[d][i] = '0;
        end
    endfunction

    function automatic void model_edge();
        for (int d = 0; d < NDUT; d++) begin
            int lat = d + 1;
            int a   = int'(addr);
            bit was_busy;
            bit acc;
            was_busy = (cyc >= last_acc[d] + 1) && (cyc <= last_acc[d] + lat - 1);
            acc      = rd_req && !was_busy;
            if (OVR_EN && rd_req && was_busy) exp_ovr[d] = 1'b1;
            else if (acc)                     exp_ovr[d] = 1'b0;
            if (acc) begin
                if (a >= STS_BASE && a < STS_BASE + NUM_STS) begin
                    pend_data[d] = status_in[(a-STS_BASE)*8 +: 8] | m_sticky[d][a-STS_BASE];
                    pend_err[d]  = 1'b0;
                    m_sticky[d][a-STS_BASE] = '0;
                end else if (a < NUM_REGS) begin
                    pend_data[d] = data_reg[a*8 +: 8];
                    pend_err[d]  = 1'b0;
                end else begin
                    pend_data[d] = '0;
                    pend_err[d]  = 1'b1;
                end
                last_acc[d] = cyc;
                pend_due[d] = cyc + lat - 1;
            end
            for (int i = 0; i < NUM_STS; i++) m_sticky[d][i] |= sts_event[i*8 +: 8];
            exp_valid[d] = (pend_due[d] == cyc);
            exp_err[d]   = exp_valid[d] && pend_err[d];
            if (exp_valid[d]) exp_data[d] = pend_data[d];
            exp_busy[d]  = (cyc >= last_acc[d]) && (cyc <= last_acc[d] + lat - 2);
        end
        cyc++;
    endfunction

    task automatic check_all();
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("lat%0d DataRd", d + 1),    32'(data_rd[d]),  32'(exp_data[d]));
            check($sformatf("lat%0d RdValid", d + 1),   32'(rd_valid[d]), 32'(exp_valid[d]));
            check($sformatf("lat%0d RdErr", d + 1),     32'(rd_err[d]),   32'(exp_err[d]));
            check($sformatf("lat%0d Busy", d + 1),      32'(busy[d]),     32'(exp_busy[d]));
            check($sformatf("lat%0d RdOverrun", d + 1), 32'(rd_ovr[d]),   32'(exp_ovr[d]));
        end
    endtask

    // One clock: model follows the edge, outputs are compared 2 ns later.
    task automatic step();
        @(posedge clk);
        if (rst_n) model_edge();
        #2;
        check_all();
    endtask

    task automatic idle(input int n);
        rd_req    = 1'b0;
        sts_event = '0;
        repeat (n) step();
    endtask

    task automatic read_req(input logic [7:0] a);
        addr   = a;
        rd_req = 1'b1;
        step();
        rd_req = 1'b0;
    endtask

    typedef struct {
        logic [7:0] addr;
        logic [7:0] reg_val;
        logic [7:0] exp_data;
        logic       exp_err;
    } vec_t;

    vec_t tbl [9];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not finish, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        int nv;
        n_cmp     = 0;
        n_bad     = 0;
        cyc       = 0;
        rd_req    = 1'b0;
        addr      = '0;
        data_reg  = '0;
        status_in = '0;
        sts_event = '0;
        model_reset();
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;

        // Single-cycle reads through the lat1 instance.
        tbl[0] = '{8'd3,   8'hA5, 8'hA5, 1'b0};
        tbl[1] = '{8'd0,   8'h5A, 8'h5A, 1'b0};
        tbl[2] = '{8'd31,  8'hC3, 8'hC3, 1'b0};
        tbl[3] = '{8'd32,  8'h77, 8'h00, 1'b1};
        tbl[4] = '{8'h40,  8'h11, 8'h00, 1'b1};
        tbl[5] = '{8'hFF,  8'h22, 8'h00, 1'b1};
        tbl[6] = '{8'd6,   8'h99, 8'h99, 1'b0};
        tbl[7] = '{8'd5,   8'h00, 8'h80, 1'b0};
        tbl[8] = '{8'd4,   8'h00, 8'h01, 1'b0};
        status_in = {8'h80, 8'h01};
        for (int i = 0; i < 9; i++) begin
            if (int'(tbl[i].addr) < NUM_REGS && int'(tbl[i].addr) != 4 && int'(tbl[i].addr) != 5)
                data_reg[int'(tbl[i].addr)*8 +: 8] = tbl[i].reg_val;
            read_req(tbl[i].addr);
            check($sformatf("tbl%0d DataRd", i), 32'(data_rd[0]), 32'(tbl[i].exp_data));
            check($sformatf("tbl%0d RdValid", i), 32'(rd_valid[0]), 32'd1);
            check($sformatf("tbl%0d RdErr", i), 32'(rd_err[0]), 32'(tbl[i].exp_err));
            idle(1);
            check($sformatf("tbl%0d RdValid after", i), 32'(rd_valid[0]), 32'd0);
            check($sformatf("tbl%0d RdErr after", i), 32'(rd_err[0]), 32'd0);
            idle(3);
        end

        // Captured data is immune to a later DataReg change (lat3).
        data_reg[14*8 +: 8] = 8'h3C;
        read_req(8'd14);
        data_reg[14*8 +: 8] = 8'hFF;
        check("lat3 busy T", 32'(busy[2]), 32'd1);
        step();
        check("lat3 busy T+1", 32'(busy[2]), 32'd1);
        check("lat3 no valid T+1", 32'(rd_valid[2]), 32'd0);
        step();
        check("lat3 valid T+2", 32'(rd_valid[2]), 32'd1);
        check("lat3 data T+2", 32'(data_rd[2]), 32'h3C);
        check("lat3 busy T+2", 32'(busy[2]), 32'd0);
        idle(4);

        // Status overlay with sticky clear-on-read.
        status_in = {8'h80, 8'h01};
        sts_event = 16'h0010;
        step();
        sts_event = '0;
        read_req(8'd4);
        check("sts first read", 32'(data_rd[0]), 32'h11);
        idle(4);
        read_req(8'd4);
        check("sts second read", 32'(data_rd[0]), 32'h01);
        idle(4);
        sts_event = 16'h0010;
        step();
        read_req(8'd4);
        sts_event = '0;
        check("sts coincident read", 32'(data_rd[0]), 32'h11);
        idle(4);
        read_req(8'd4);
        check("sts kept after coincident", 32'(data_rd[0]), 32'h11);
        idle(4);
        read_req(8'd4);
        check("sts cleared", 32'(data_rd[0]), 32'h01);
        idle(4);

        // Request while busy (lat2): dropped, flagged when the overrun feature is built.
        nv     = 0;
        addr   = 8'd3;
        rd_req = 1'b1;
        step();
        nv += int'(rd_valid[1]);
        step();
        nv += int'(rd_valid[1]);
        rd_req = 1'b0;
        check("lat2 overrun set", 32'(rd_ovr[1]), 32'(OVR_EN));
        for (int i = 0; i < 4; i++) begin
            step();
            nv += int'(rd_valid[1]);
        end
        check("lat2 single valid", 32'(nv), 32'd1);
        check("lat2 overrun held", 32'(rd_ovr[1]), 32'(OVR_EN));
        read_req(8'd6);
        check("lat2 overrun cleared", 32'(rd_ovr[1]), 32'd0);
        idle(4);

        // Reset in the middle of a lat4 read.
        read_req(8'd3);
        step();
        step();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        check("rst DataRd lat4", 32'(data_rd[3]), 32'd0);
        check("rst Busy lat4", 32'(busy[3]), 32'd0);
        nv = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            nv += int'(rd_valid[3]);
        end
        check("rst no valid lat4", 32'(nv), 32'd0);
        rst_n = 1'b1;
        data_reg[3*8 +: 8] = 8'h5A;
        read_req(8'd3);
        idle(3);
        check("post-rst valid lat4", 32'(rd_valid[3]), 32'd1);
        check("post-rst data lat4", 32'(data_rd[3]), 32'h5A);
        idle(4);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            int k;
            rd_req = ($urandom_range(0, 99) < 55);
            case ($urandom_range(0, 9))
                0:       addr = 8'($urandom);
                1, 2:    addr = 8'(STS_BASE + $urandom_range(0, NUM_STS - 1));
                default: addr = 8'($urandom_range(0, 35));
            endcase
            if ($urandom_range(0, 3) == 0) begin
                k = $urandom_range(0, NUM_REGS - 1);
                data_reg[k*8 +: 8] = 8'($urandom);
            end
            if ($urandom_range(0, 7) == 0) status_in = 16'($urandom);
            sts_event = 16'($urandom & $urandom & $urandom & $urandom);
            if (n == 1500) begin
                rst_n = 1'b0;
                model_reset();
                #1;
                check_all();
                step();
                rst_n = 1'b1;
            end
            step();
        end
        idle(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
